// File: rtl/dma_job_scheduler.sv
// Wishbone-programmed job scheduler: queues DMA job ids and launches the FIR, QS and MM
// engines one at a time, with per-job timeout and cycle accounting.
module dma_job_scheduler #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_F000,
  parameter int unsigned QDEPTH    = 8,
  parameter int unsigned TO_W      = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0]  eng_start,
  input  logic [2:0]  eng_done,
  output logic        busy,
  output logic        irq
);

  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLaunch = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StCheck  = 2'd3;

  localparam logic [7:0] OffCtrl    = 8'h00;
  localparam logic [7:0] OffStatus  = 8'h04;
  localparam logic [7:0] OffQueue   = 8'h08;
  localparam logic [7:0] OffTimeout = 8'h0C;
  localparam logic [7:0] OffCycles  = 8'h10;

  localparam logic [1:0] JobNop = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [1:0]      cur_id_q;
  logic [TO_W-1:0] cnt_q, cnt_inc;
  logic [TO_W-1:0] cycles_q;
  logic [TO_W-1:0] timeout_q;
  logic            done_q, tmo_q, ovf_q, irq_en_q;

  logic [1:0]      fifo_mem [QDEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            fifo_full, fifo_empty;
  logic [1:0]      head;

  logic            hit, req, wr, rd_en;
  logic [7:0]      off;
  logic            wr_ctrl, wr_status, wr_queue, wr_timeout;
  logic            go, abort;
  logic            push_ok, push_drop;
  logic            pop, flush, set_done, set_tmo, latch_cycles, clr_cnt, inc_cnt;
  logic            busy_int, done_cur;
  logic [3:0]      done_ext, launch_oh;
  logic [3:0]      count4;
  logic [31:0]     rd_data;
  logic            unused_inputs;

  assign unused_inputs = ^{wbs_sel_i, wbs_dat_i};

  assign hit   = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req   = hit & wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr    = req & wbs_we_i;
  assign rd_en = req & ~wbs_we_i;
  assign off   = wbs_adr_i[7:0];

  assign wr_ctrl    = wr && (off == OffCtrl);
  assign wr_status  = wr && (off == OffStatus);
  assign wr_queue   = wr && (off == OffQueue);
  assign wr_timeout = wr && (off == OffTimeout);

  // ABORT dominates a simultaneous GO
  assign abort = wr_ctrl & wbs_dat_i[1];
  assign go    = wr_ctrl & wbs_dat_i[0] & ~wbs_dat_i[1];

  assign fifo_full  = (count_q == CW'(QDEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem[rd_ptr_q];
  assign push_ok    = wr_queue & ~fifo_full;
  assign push_drop  = wr_queue & fifo_full;

  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + TO_W'(1);
  assign done_ext = {1'b0, eng_done};
  assign done_cur = done_ext[cur_id_q];
  assign busy_int = (state_q != StIdle);
  assign count4   = 4'(count_q);

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    flush        = 1'b0;
    set_done     = 1'b0;
    set_tmo      = 1'b0;
    latch_cycles = 1'b0;
    clr_cnt      = 1'b0;
    inc_cnt      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          if (!fifo_empty) state_d = StLaunch;
          else             set_done = 1'b1;
        end
      end
      StLaunch: begin
        pop     = 1'b1;
        clr_cnt = 1'b1;
        state_d = (head == JobNop) ? StCheck : StWait;
      end
      StWait: begin
        // The count includes the current cycle, so it equals cycles elapsed since the start pulse
        inc_cnt = 1'b1;
        if (done_cur) begin
          latch_cycles = 1'b1;
          state_d      = StCheck;
        end else if ((timeout_q != '0) && (cnt_inc == timeout_q)) begin
          set_tmo = 1'b1;
          flush   = 1'b1;
          state_d = StIdle;
        end
      end
      StCheck: begin
        if (fifo_empty) begin
          set_done = 1'b1;
          state_d  = StIdle;
        end else begin
          state_d = StLaunch;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d      = StIdle;
      flush        = 1'b1;
      pop          = 1'b0;
      set_done     = 1'b0;
      set_tmo      = 1'b0;
      latch_cycles = 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    case (off)
      OffCtrl:    rd_data[2] = irq_en_q;
      OffStatus: begin
        rd_data[0]    = busy_int;
        rd_data[1]    = done_q;
        rd_data[2]    = tmo_q;
        rd_data[3]    = ovf_q;
        rd_data[5:4]  = cur_id_q;
        rd_data[11:8] = count4;
      end
      OffTimeout: rd_data[TO_W-1:0] = timeout_q;
      OffCycles:  rd_data[TO_W-1:0] = cycles_q;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= wbs_dat_i[1:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      cur_id_q  <= '0;
      cnt_q     <= '0;
      cycles_q  <= '0;
      timeout_q <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      ovf_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      state_q   <= state_d;
      wbs_ack_o <= req;
      wbs_dat_o <= rd_en ? rd_data : '0;

      if (wr_ctrl)    irq_en_q  <= wbs_dat_i[2];
      if (wr_timeout) timeout_q <= wbs_dat_i[TO_W-1:0];
      if (pop)        cur_id_q  <= head;

      if (clr_cnt)      cnt_q <= '0;
      else if (inc_cnt) cnt_q <= cnt_inc;
      if (latch_cycles) cycles_q <= cnt_inc;

      // Hardware set wins over a same-cycle write-1-to-clear
      done_q <= set_done  | (done_q & ~(wr_status & wbs_dat_i[1]));
      tmo_q  <= set_tmo   | (tmo_q  & ~(wr_status & wbs_dat_i[2]));
      ovf_q  <= push_drop | (ovf_q  & ~(wr_status & wbs_dat_i[3]));

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
        if (push_ok && !pop)      count_q <= count_q + CW'(1);
        else if (pop && !push_ok) count_q <= count_q - CW'(1);
      end
    end
  end

  always_comb begin
    launch_oh = 4'b0001 << head;
    eng_start = 3'b000;
    if ((state_q == StLaunch) && !wb_rst_i) eng_start = launch_oh[2:0];
  end

  assign busy = busy_int & ~wb_rst_i;
  assign irq  = irq_en_q & (done_q | tmo_q) & ~wb_rst_i;

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Directed bench for dma_job_scheduler: a register-access vector table followed by
// hand-written multi-cycle sequences for job execution, overflow, timeout, NOP, abort and reset.
`timescale 1ns/1ps
module tb_dma_job_scheduler;

  localparam logic [31:0] B        = 32'h3000_F000;
  localparam logic [31:0] ACtrl    = B + 32'h00;
  localparam logic [31:0] AStatus  = B + 32'h04;
  localparam logic [31:0] AQueue   = B + 32'h08;
  localparam logic [31:0] ATimeout = B + 32'h0C;
  localparam logic [31:0] ACycles  = B + 32'h10;

  logic        clk;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] wdat, adr;
  logic        ack;
  logic [31:0] rdat;
  logic [2:0]  eng_start;
  logic [2:0]  eng_done;
  logic        busy, irq;

  dma_job_scheduler #(
    .BASE_ADDR(B),
    .QDEPTH   (8),
    .TO_W     (16)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_dat_i(wdat),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .eng_start(eng_start),
    .eng_done (eng_done),
    .busy     (busy),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        exp_ack;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One Wishbone access; gives up after 4 edges without an acknowledge
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] r, output logic acked);
    adr   = a;
    wdat  = d;
    we    = w;
    stb   = 1'b1;
    cyc   = 1'b1;
    acked = 1'b0;
    r     = '0;
    for (int n = 0; n < 4 && !acked; n++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        acked = 1'b1;
        r     = rdat;
      end
    end
    stb = 1'b0;
    cyc = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic        k;
    bus(1'b1, a, d, r, k);
    if (!k) check("write ack", {63'b0, k}, 64'd1);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    logic k;
    bus(1'b0, a, 32'h0, r, k);
    if (!k) check("read ack", {63'b0, k}, 64'd1);
  endtask

  task automatic do_reset();
    stb      = 1'b0;
    cyc      = 1'b0;
    we       = 1'b0;
    wdat     = '0;
    adr      = '0;
    eng_done = 3'b000;
    rst      = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        k;
    logic [2:0]  st_log [4];
    int          n_st;
    int          dly [3];
    logic        saw0;

    sel = 4'hF;
    vecs[0]  = '{1'b0, AStatus,          32'h0,        32'h0,    1'b1};
    vecs[1]  = '{1'b0, ACtrl,            32'h0,        32'h0,    1'b1};
    vecs[2]  = '{1'b0, ATimeout,         32'h0,        32'h0,    1'b1};
    vecs[3]  = '{1'b0, ACycles,          32'h0,        32'h0,    1'b1};
    vecs[4]  = '{1'b1, ATimeout,         32'h0001_ABCD, 32'h0,   1'b1};
    vecs[5]  = '{1'b0, ATimeout,         32'h0,        32'hABCD, 1'b1};
    vecs[6]  = '{1'b1, ACtrl,            32'h4,        32'h0,    1'b1};
    vecs[7]  = '{1'b0, ACtrl,            32'h0,        32'h4,    1'b1};
    vecs[8]  = '{1'b0, B + 32'h20,       32'h0,        32'h0,    1'b1};
    vecs[9]  = '{1'b1, B + 32'h14,       32'hFFFF_FFFF, 32'h0,   1'b1};
    vecs[10] = '{1'b0, B + 32'h14,       32'h0,        32'h0,    1'b1};
    vecs[11] = '{1'b0, 32'h3000_E004,    32'h0,        32'h0,    1'b0};
    vecs[12] = '{1'b1, AQueue,           32'h1,        32'h0,    1'b1};
    vecs[13] = '{1'b1, AQueue,           32'h2,        32'h0,    1'b1};
    vecs[14] = '{1'b0, AStatus,          32'h0,        32'h200,  1'b1};
    vecs[15] = '{1'b1, ACtrl,            32'h2,        32'h0,    1'b1};
    vecs[16] = '{1'b0, AStatus,          32'h0,        32'h0,    1'b1};
    vecs[17] = '{1'b0, ACtrl,            32'h0,        32'h0,    1'b1};
    vecs[18] = '{1'b1, ACtrl,            32'h1,        32'h0,    1'b1};
    vecs[19] = '{1'b0, AStatus,          32'h0,        32'h2,    1'b1};
    vecs[20] = '{1'b1, AStatus,          32'h2,        32'h0,    1'b1};
    vecs[21] = '{1'b0, AStatus,          32'h0,        32'h0,    1'b1};
    vecs[22] = '{1'b1, ATimeout,         32'h0,        32'h0,    1'b1};

    do_reset();
    check("reset outputs", {26'b0, ack, rdat, eng_start, busy, irq}, 64'h0);

    for (int i = 0; i < 23; i++) begin
      bus(vecs[i].we, vecs[i].adr, vecs[i].wd, r, k);
      check($sformatf("vec%0d", i), {31'b0, k, (vecs[i].we ? 32'h0 : r)},
            {31'b0, vecs[i].exp_ack, vecs[i].exp});
    end

    // Three jobs back to back, each engine finishing 20 cycles after its start
    do_reset();
    wr(AQueue, 32'h0);
    wr(AQueue, 32'h1);
    wr(AQueue, 32'h2);
    wr(ACtrl, 32'h1);
    n_st = 0;
    dly  = '{0, 0, 0};
    for (int c = 0; c < 300; c++) begin
      if (eng_start != 3'b000) begin
        if (n_st < 4) st_log[n_st] = eng_start;
        n_st++;
        for (int e = 0; e < 3; e++) if (eng_start[e]) dly[e] = 20;
      end
      if (!busy) break;
      @(posedge clk);
      #1;
      eng_done = 3'b000;
      for (int e = 0; e < 3; e++) begin
        if (dly[e] > 0) begin
          dly[e]--;
          if (dly[e] == 0) eng_done[e] = 1'b1;
        end
      end
    end
    eng_done = 3'b000;
    check("seq start count", 64'(n_st), 64'd3);
    check("seq start order", {55'b0, st_log[0], st_log[1], st_log[2]},
          {55'b0, 3'b001, 3'b010, 3'b100});
    check("seq busy end", {63'b0, busy}, 64'd0);
    rd(AStatus, r);
    check("seq status", {32'b0, r}, 64'h22);
    rd(ACycles, r);
    check("seq cycles", {32'b0, r}, 64'd20);
    check("seq irq off", {63'b0, irq}, 64'd0);

    // Overflow: nine pushes into an eight-deep queue
    do_reset();
    for (int i = 0; i < 9; i++) wr(AQueue, 32'(i % 4));
    rd(AStatus, r);
    check("ovf status", {32'b0, r}, 64'h808);
    wr(AStatus, 32'h8);
    rd(AStatus, r);
    check("ovf cleared", {32'b0, r}, 64'h800);

    // Timeout with no done; the queued FIR job must be flushed
    do_reset();
    wr(ACtrl, 32'h4);
    wr(ATimeout, 32'd5);
    wr(AQueue, 32'h2);
    wr(AQueue, 32'h0);
    wr(ACtrl, 32'h5);
    check("tmo start mm", {61'b0, eng_start}, 64'b100);
    saw0 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (eng_start[0]) saw0 = 1'b1;
      if (c == 5) check("tmo pending", {62'b0, busy, irq}, 64'b10);
      if (c == 6) check("tmo fired", {62'b0, busy, irq}, 64'b01);
    end
    check("tmo no fir start", {63'b0, saw0}, 64'd0);
    rd(AStatus, r);
    check("tmo status", {32'b0, r}, 64'h24);

    // NOP followed by QS; a done from a non-current engine is ignored
    do_reset();
    wr(AQueue, 32'h3);
    wr(AQueue, 32'h1);
    wr(ACtrl, 32'h1);
    check("nop cycle1", {61'b0, eng_start}, 64'b000);
    cycles(1);
    check("nop cycle2", {61'b0, eng_start}, 64'b000);
    cycles(1);
    check("nop cycle3", {61'b0, eng_start}, 64'b010);
    cycles(1);
    eng_done = 3'b001;
    cycles(5);
    check("foreign done busy", {63'b0, busy}, 64'd1);
    rd(AStatus, r);
    check("foreign done status", {32'b0, r}, 64'h11);
    eng_done = 3'b010;
    cycles(4);
    eng_done = 3'b000;
    check("qs done busy", {63'b0, busy}, 64'd0);
    rd(AStatus, r);
    check("qs done status", {32'b0, r}, 64'h12);

    // ABORT mid-WAIT keeps DONE, flushes the rest; GO+ABORT behaves as ABORT
    do_reset();
    wr(ACtrl, 32'h1);
    wr(AQueue, 32'h0);
    wr(AQueue, 32'h1);
    wr(ACtrl, 32'h1);
    cycles(3);
    wr(ACtrl, 32'h2);
    check("abort busy", {63'b0, busy}, 64'd0);
    saw0 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycles(1);
      if (eng_start != 3'b000) saw0 = 1'b1;
    end
    check("abort no start", {63'b0, saw0}, 64'd0);
    rd(AStatus, r);
    check("abort status", {32'b0, r}, 64'h02);
    wr(AQueue, 32'h1);
    wr(ACtrl, 32'h3);
    check("go+abort idle", {60'b0, busy, eng_start}, 64'h0);
    rd(AStatus, r);
    check("go+abort status", {32'b0, r}, 64'h02);

    // Reset in the middle of a job
    do_reset();
    wr(ACtrl, 32'h5);
    wr(AQueue, 32'h0);
    wr(ACtrl, 32'h5);
    cycles(3);
    check("pre-reset busy irq", {62'b0, busy, irq}, 64'b11);
    rst = 1'b1;
    cycles(1);
    check("in-reset outputs", {26'b0, ack, rdat, eng_start, busy, irq}, 64'h0);
    rst      = 1'b0;
    eng_done = 3'b001;
    saw0     = 1'b0;
    for (int c = 0; c < 25; c++) begin
      cycles(1);
      if (eng_start != 3'b000 || busy) saw0 = 1'b1;
    end
    eng_done = 3'b000;
    check("post-reset quiet", {63'b0, saw0}, 64'd0);
    rd(AStatus, r);
    check("post-reset status", {32'b0, r}, 64'h0);
    rd(ACycles, r);
    check("post-reset cycles", {32'b0, r}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
